xyz_to_cct_converter: RTL and testbench
=======================================

XYZ_TO_CCT_CONVERTER -- requirements
Module: xyz_to_cct_converter

Interface
REQ-001 Clock and reset SHALL be single clock `clk`, reset synchronous active-high `rst`.
REQ-002 `clk` SHALL be an input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-003 `rst` SHALL be an input, 1 bit, synchronous active-high reset.
REQ-004 `xyz_in` SHALL be an input, 96 bits: X in [31:0], Y in [63:32], Z in [95:64], each unsigned Q16.16.
REQ-005 `xyz_valid` SHALL be an input, 1 bit, qualifying `xyz_in` for one cycle.
REQ-006 `cct_out` SHALL be an output, 16 bits, correlated colour temperature in Kelvin, unsigned integer.
REQ-007 `cct_valid` SHALL be an output, 1 bit, a one-cycle pulse qualifying `cct_out`.
REQ-008 `busy` SHALL be an output, 1 bit, high from acceptance until the `cct_valid` cycle inclusive.

Function
REQ-009 A sample SHALL be accepted in IDLE when `xyz_valid`=1 and `busy`=0; `xyz_valid` while busy SHALL be ignored (no queueing).
REQ-010 The FSM SHALL use states IDLE->SUM->DIV_X->DIV_Y->PREP->DIV_N->POLY->DONE->IDLE; no other transitions except reset.
REQ-011 SUM: S=X+Y+Z at 34-bit width, no overflow.
REQ-012 DIV_X/DIV_Y: x=X/S, y=Y/S by a shared restoring divider, 1 quotient bit/cycle, 17 cycles each, unsigned Q1.16 result, truncated.
REQ-013 PREP: num=x-0.3320, den=0.1858-y, signed Q2.16; constants 21758 and 12177 (Q0.16 codes).
REQ-014 DIV_N: n=num/den by the same divider on magnitudes, 18 cycles, with the sign applied afterwards.
REQ-015 n SHALL be saturated to [-1.0,+1.0]; if |den| < 2^-9, n SHALL be set to +/-1.0 with sign(num) XOR sign(den), and num=0 SHALL give n=0.
REQ-016 POLY: Horner CCT=((449*n+3525)*n+6823.3)*n+5520.33, 3 cycles, one signed 32x32 multiplier, Q16.16.
REQ-017 Coefficient Q16.16 codes SHALL be 29425664, 231014400, 447171789 and 361780347.
REQ-018 DONE SHALL round the result to the nearest integer (half up), clamp per REQ-024/025, register `cct_out` and pulse `cct_valid` for 1 cycle.
REQ-019 Latency SHALL be fixed: `cct_valid` SHALL be high in the 58th cycle after the acceptance cycle for every input.
REQ-020 For S=0 the datapath SHALL still run and `cct_out` SHALL be forced to 6500, with latency unchanged.
REQ-021 `cct_out` SHALL hold its value until the next DONE; a new sample SHALL be accepted in the cycle after `cct_valid`.

Reset
REQ-022 With `rst`=1 at a clock edge: state=IDLE, `cct_out`=0, `cct_valid`=0, `busy`=0, and all datapath registers zeroed.
REQ-023 Reset asserted mid-computation SHALL abort it; no `cct_valid` for the aborted sample; the first sample after reset behaves per REQ-019.

Configuration
REQ-024 With macro XYZ_TO_CCT_CLAMP_EN defined, `cct_out` SHALL be clamped to [3000,8000], matching the CCT-to-XYZ converter's input range.
REQ-025 Without XYZ_TO_CCT_CLAMP_EN, `cct_out` SHALL only saturate to [0,65535]; latency is identical in both builds.

Verification
REQ-026 D65 X=0.9505,Y=1.0,Z=1.0890 -> `cct_out`=6505+/-3 after exactly 58 cycles, `busy` high throughout.
REQ-027 D50 X=0.9642,Y=1.0,Z=0.8251 -> `cct_out`=5001+/-3; then an immediate back-to-back sample is accepted the cycle after `cct_valid`.
REQ-028 x=0.5266,y=0.4133 (X=1.2741,Y=1.0,Z=0.1455) -> 3000 with XYZ_TO_CCT_CLAMP_EN, 1982+/-3 without.
REQ-029 X=Y=Z=0 -> `cct_out`=6500 at cycle 58; `xyz_valid` pulsed at cycle 10 -> ignored, and only one `cct_valid` results.
REQ-030 `rst` pulsed at cycle 30 of a D65 run -> no `cct_valid`, outputs 0; a D50 sample then gives 5001+/-3 at cycle 58.

Source files
------------

// File: rtl/xyz_to_cct_converter.sv
// xyz_to_cct_converter: CIE XYZ (unsigned Q16.16 each) to correlated colour temperature in
// Kelvin using McCamy's cubic approximation. The latency is fixed at 58 cycles. One restoring
// divider is shared by x, y and n, and one signed 32x32 multiplier evaluates the polynomial.
// Build option: define XYZ_TO_CCT_CLAMP_EN to clamp cct_out to [3000,8000]. Without it,
// cct_out only saturates to [0,65535].
module xyz_to_cct_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] xyz_in,
  input  logic        xyz_valid,
  output logic [15:0] cct_out,
  output logic        cct_valid,
  output logic        busy
);

  localparam logic [16:0] XEpi    = 17'd21758;  // 0.3320 in Q0.16
  localparam logic [16:0] YEpi    = 17'd12177;  // 0.1858 in Q0.16
  localparam logic [17:0] DenTiny = 18'd128;    // 2^-9 in Q.16

  localparam logic signed [31:0] CoefA = 32'sd29425664;   // 449
  localparam logic signed [31:0] CoefB = 32'sd231014400;  // 3525
  localparam logic signed [31:0] CoefC = 32'sd447171789;  // 6823.3
  localparam logic signed [31:0] CoefD = 32'sd361780347;  // 5520.33

  localparam logic [15:0] CctDefault = 16'd6500;
`ifdef XYZ_TO_CCT_CLAMP_EN
  localparam logic signed [32:0] CctMin = 33'sd3000;
  localparam logic signed [32:0] CctMax = 33'sd8000;
`else
  localparam logic signed [32:0] CctMin = 33'sd0;
  localparam logic signed [32:0] CctMax = 33'sd65535;
`endif

  typedef enum logic [2:0] {
    StIdle, StSum, StDivX, StDivY, StPrep, StDivN, StPoly, StDone
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        x_in_q, x_in_d, y_in_q, y_in_d, z_in_q, z_in_d;
  logic               s_zero_q, s_zero_d;
  logic [34:0]        rem_q, rem_d;
  logic [33:0]        dvs_q, dvs_d;
  logic [17:0]        quo_q, quo_d;
  logic [17:0]        sh_q, sh_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [16:0]        xc_q, xc_d, yc_q, yc_d;
  logic               num_neg_q, num_neg_d, den_neg_q, den_neg_d;
  logic               num_zero_q, num_zero_d, den_tiny_q, den_tiny_d, ovf_q, ovf_d;
  logic signed [31:0] n_q, n_d, acc_q, acc_d;
  logic [15:0]        cct_q, cct_d;
  logic               cct_valid_q, cct_valid_d;

  // Combinational helpers
  logic [33:0]        sum;
  logic [34:0]        trial, rem_next;
  logic               q_bit;
  logic [17:0]        quo_new;
  logic signed [18:0] num, den;
  logic [17:0]        num_mag, den_mag;
  logic [16:0]        n_mag;
  logic signed [31:0] poly_a, poly_coef, acc_next;
  logic signed [63:0] prod;
  logic signed [32:0] rnd, cct_int;
  logic [15:0]        cct_fin;
  logic               unused_prod;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed-length walk through the pipeline steps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xyz_valid) state_d = StSum;
      StSum:   state_d = StDivX;
      StDivX:  if (cnt_q == 5'd16) state_d = StDivY;
      StDivY:  if (cnt_q == 5'd16) state_d = StPrep;
      StPrep:  state_d = StDivN;
      StDivN:  if (cnt_q == 5'd17) state_d = StPoly;
      StPoly:  if (cnt_q == 5'd2) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    cct_out   = cct_q;
    cct_valid = cct_valid_q;
  end

  // Shared arithmetic: restoring-divider step, chromaticity offsets, Horner step and rounding
  always_comb begin
    sum      = {2'b00, x_in_q} + {2'b00, y_in_q} + {2'b00, z_in_q};

    trial    = {rem_q[33:0], sh_q[17]};
    q_bit    = (trial >= {1'b0, dvs_q});
    rem_next = q_bit ? (trial - {1'b0, dvs_q}) : trial;
    quo_new  = {quo_q[16:0], q_bit};

    num      = $signed({2'b00, xc_q}) - $signed({2'b00, XEpi});
    den      = $signed({2'b00, YEpi}) - $signed({2'b00, yc_q});
    num_mag  = num[18] ? 18'(-num) : num[17:0];
    den_mag  = den[18] ? 18'(-den) : den[17:0];

    // n is at most 1.0, so any quotient at or above 2^16 saturates
    if (num_zero_q)                                      n_mag = 17'd0;
    else if (den_tiny_q || ovf_q || (|quo_new[17:16]))   n_mag = 17'h10000;
    else                                                 n_mag = quo_new[16:0];

    poly_a = (cnt_q == 5'd0) ? CoefA : acc_q;
    if (cnt_q == 5'd0)      poly_coef = CoefB;
    else if (cnt_q == 5'd1) poly_coef = CoefC;
    else                    poly_coef = CoefD;
    prod     = poly_a * n_q;
    acc_next = $signed(prod[47:16]) + poly_coef;

    // Round half up, then clamp to the build's output range
    rnd     = $signed({acc_next[31], acc_next}) + 33'sd32768;
    cct_int = rnd >>> 16;
    if (cct_int < CctMin)      cct_fin = CctMin[15:0];
    else if (cct_int > CctMax) cct_fin = CctMax[15:0];
    else                       cct_fin = cct_int[15:0];
    if (s_zero_q) cct_fin = CctDefault;
  end

  assign unused_prod = ^{prod[63:48], prod[15:0]};

  // Datapath next-state: each state loads the divider for the following one
  always_comb begin
    x_in_d      = x_in_q;
    y_in_d      = y_in_q;
    z_in_d      = z_in_q;
    s_zero_d    = s_zero_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    sh_d        = sh_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    num_neg_d   = num_neg_q;
    den_neg_d   = den_neg_q;
    num_zero_d  = num_zero_q;
    den_tiny_d  = den_tiny_q;
    ovf_d       = ovf_q;
    n_d         = n_q;
    acc_d       = acc_q;
    cct_d       = cct_q;
    cct_valid_d = 1'b0;
    cnt_d       = (state_q == StIdle || state_d != state_q) ? 5'd0 : cnt_q + 5'd1;

    unique case (state_q)
      StIdle: begin
        if (xyz_valid) begin
          x_in_d = xyz_in[31:0];
          y_in_d = xyz_in[63:32];
          z_in_d = xyz_in[95:64];
        end
      end
      StSum: begin
        // Dividend X<<16 is fed as X>>1 preloaded plus 17 shifted-in bits
        s_zero_d = (sum == 34'd0);
        dvs_d    = sum;
        rem_d    = {4'd0, x_in_q[31:1]};
        sh_d     = {x_in_q[0], 17'd0};
        quo_d    = 18'd0;
      end
      StDivX, StDivY: begin
        rem_d = rem_next;
        quo_d = quo_new;
        sh_d  = {sh_q[16:0], 1'b0};
        if (cnt_q == 5'd16) begin
          if (state_q == StDivX) begin
            xc_d  = quo_new[16:0];
            rem_d = {4'd0, y_in_q[31:1]};
            sh_d  = {y_in_q[0], 17'd0};
            quo_d = 18'd0;
          end else begin
            yc_d  = quo_new[16:0];
          end
        end
      end
      StPrep: begin
        num_neg_d  = num[18];
        den_neg_d  = den[18];
        num_zero_d = (num == 19'sd0);
        den_tiny_d = (den_mag < DenTiny);
        ovf_d      = ({2'b00, num_mag[17:2]} >= den_mag);
        dvs_d      = {16'd0, den_mag};
        rem_d      = {19'd0, num_mag[17:2]};
        sh_d       = {num_mag[1:0], 16'd0};
        quo_d      = 18'd0;
      end
      StDivN: begin
        rem_d = rem_next;
        quo_d = quo_new;
        sh_d  = {sh_q[16:0], 1'b0};
        if (cnt_q == 5'd17) begin
          n_d = (num_neg_q ^ den_neg_q) ? -$signed({15'd0, n_mag}) : $signed({15'd0, n_mag});
        end
      end
      StPoly: begin
        acc_d = acc_next;
        if (cnt_q == 5'd2) begin
          cct_d       = cct_fin;
          cct_valid_d = 1'b1;
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      x_in_q      <= '0;
      y_in_q      <= '0;
      z_in_q      <= '0;
      s_zero_q    <= 1'b0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      num_neg_q   <= 1'b0;
      den_neg_q   <= 1'b0;
      num_zero_q  <= 1'b0;
      den_tiny_q  <= 1'b0;
      ovf_q       <= 1'b0;
      n_q         <= '0;
      acc_q       <= '0;
      cct_q       <= '0;
      cct_valid_q <= 1'b0;
    end else begin
      x_in_q      <= x_in_d;
      y_in_q      <= y_in_d;
      z_in_q      <= z_in_d;
      s_zero_q    <= s_zero_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      num_neg_q   <= num_neg_d;
      den_neg_q   <= den_neg_d;
      num_zero_q  <= num_zero_d;
      den_tiny_q  <= den_tiny_d;
      ovf_q       <= ovf_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      cct_q       <= cct_d;
      cct_valid_q <= cct_valid_d;
    end
  end

endmodule

// File: tb/tb_xyz_to_cct_converter.sv
// Bench for xyz_to_cct_converter: table of XYZ codes with hand-computed CCT, latency and
// handshake checks, plus sequences for the ignored-valid, idle watch and mid-run reset cases.
module tb_xyz_to_cct_converter;

  logic        clk;
  logic        rst;
  logic [95:0] xyz_in;
  logic        xyz_valid;
  logic [15:0] cct_out;
  logic        cct_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  xyz_to_cct_converter dut (
    .clk       (clk),
    .rst       (rst),
    .xyz_in    (xyz_in),
    .xyz_valid (xyz_valid),
    .cct_out   (cct_out),
    .cct_valid (cct_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    int          exp_def;
    int          exp_clamp;
    int          tol;
    int          pulse_at;
  } vec_t;

  task automatic check(input string tag, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, act, exp, tol);
    end
  endtask

  // Entered #1 after a rising edge; returns #1 after the edge ending the cct_valid cycle,
  // or after the edge that sampled the mid-run reset.
  task automatic run_sample(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] zv,
                            input int pulse_at, input int rst_at,
                            output logic [15:0] res, output int lat, output int busy_drop);
    lat       = -1;
    res       = '0;
    busy_drop = 0;
    xyz_in    = {zv, yv, xv};
    xyz_valid = 1'b1;
    @(posedge clk);
    #1;
    xyz_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == pulse_at) xyz_valid = 1'b1;
      if (c == pulse_at + 1) xyz_valid = 1'b0;
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (!busy) busy_drop++;
      if (cct_valid) begin
        lat = c;
        res = cct_out;
      end
      @(posedge clk);
      #1;
      xyz_valid = 1'b0;
      if (c == rst_at) begin
        rst = 1'b0;
        break;
      end
      if (lat != -1) break;
    end
  endtask

  // Watches an idle stretch; ends #1 after a rising edge
  task automatic watch_idle(input int cycles, output int valids, output int busys);
    valids = 0;
    busys  = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cct_valid) valids++;
      if (busy) busys++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[8];
  logic [15:0] res;
  int          lat;
  int          drop;
  int          nv;
  int          nb;
  int          exp;

  initial begin
    vecs[0] = '{32'd62292, 32'd65536, 32'd71369, 6505, 6505, 3, 0};   // D65
    vecs[1] = '{32'd63190, 32'd65536, 32'd54074, 5001, 5001, 3, 0};   // D50, back-to-back
    vecs[2] = '{32'd83499, 32'd65536, 32'd9535, 1982, 3000, 3, 0};    // warm, x=0.5266
    vecs[3] = '{32'd65536, 32'd65536, 32'd65536, 5459, 5459, 3, 0};   // equal energy
    vecs[4] = '{32'd65536, 32'd32768, 32'd77824, 1773, 3000, 0, 0};   // |den|<2^-9, n=-1
    vecs[5] = '{32'd65536, 32'd6554, 32'd13107, 16318, 8000, 0, 0};   // n saturates to +1
    vecs[6] = '{32'd43516, 32'd40000, 32'd47556, 5520, 5520, 0, 0};   // num=0, n=0
    vecs[7] = '{32'd0, 32'd0, 32'd0, 6500, 6500, 0, 10};              // S=0, valid at cycle 10

    rst       = 1'b1;
    xyz_valid = 1'b0;
    xyz_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_cct_out", int'(cct_out), 0, 0);
    check("reset_cct_valid", int'(cct_valid), 0, 0);
    check("reset_busy", int'(busy), 0, 0);

    for (int i = 0; i < 8; i++) begin
`ifdef XYZ_TO_CCT_CLAMP_EN
      exp = vecs[i].exp_clamp;
`else
      exp = vecs[i].exp_def;
`endif
      check($sformatf("v%0d_idle_before", i), int'(busy), 0, 0);
      run_sample(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].pulse_at, 0, res, lat, drop);
      check($sformatf("v%0d_latency", i), lat, 58, 0);
      check($sformatf("v%0d_cct", i), int'(res), exp, vecs[i].tol);
      check($sformatf("v%0d_busy_low_in_run", i), drop, 0, 0);
      check($sformatf("v%0d_valid_one_cycle", i), int'(cct_valid), 0, 0);
      check($sformatf("v%0d_cct_held", i), int'(cct_out), exp, vecs[i].tol);
    end

    // The ignored valid pulse must not produce a second result
    watch_idle(70, nv, nb);
    check("ignored_valid_no_result", nv, 0, 0);
    check("ignored_valid_no_busy", nb, 0, 0);

    // Reset at cycle 30 of a D65 run aborts it
    run_sample(vecs[0].x, vecs[0].y, vecs[0].z, 0, 30, res, lat, drop);
    check("abort_no_valid_before_rst", lat, -1, 0);
    check("abort_cct_out", int'(cct_out), 0, 0);
    check("abort_cct_valid", int'(cct_valid), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    watch_idle(70, nv, nb);
    check("abort_no_late_valid", nv, 0, 0);
    check("abort_stays_idle", nb, 0, 0);
    check("abort_cct_out_after", int'(cct_out), 0, 0);

    run_sample(vecs[1].x, vecs[1].y, vecs[1].z, 0, 0, res, lat, drop);
    check("post_reset_latency", lat, 58, 0);
    check("post_reset_cct", int'(res), 5001, 3);
    check("post_reset_busy", drop, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
